// File: rtl/sync_fifo.sv
// Parametrised synchronous FIFO with show-ahead output, almost-full/empty thresholds,
// synchronous flush and optional sticky error flags (enabled by SYNC_FIFO_ERR_FLAGS_EN).
module sync_fifo #(
  parameter int W      = 8,
  parameter int DEPTH  = 32,
  parameter int AF_LVL = DEPTH - 4,
  parameter int AE_LVL = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     we,
  input  logic [W-1:0]             din,
  input  logic                     re,
  input  logic                     err_clr,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          wr_ok;
  logic          rd_ok;
  logic          run;

  // Flags decode only from the registered count, never from we/re.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LVL));
  assign almost_empty = (count <= CW'(AE_LVL));

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign wr_ok = we & (~full | re);
  assign rd_ok = re & ~empty;
  assign run   = rst_n & ~clr;

  assign dout = empty ? '0 : mem[rp];

  // NOTE: storage has no reset; stale contents are never visible because dout is masked
  // while empty and every readable slot is written before count covers it.
  always_ff @(posedge clk) begin
    if (run && wr_ok) mem[wp] <= din;
  end

  // NOTE: reset is synchronous, so it is sampled as an ordinary condition in this block;
  // all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wp <= wp + AW'(1);
      if (rd_ok) rp <= rp + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic ovf_set;
  logic udf_set;

  assign ovf_set = we & full & ~re;
  assign udf_set = re & empty;

  // A set event outranks err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (err_clr) overflow <= 1'b0;
      if (udf_set)      underflow <= 1'b1;
      else if (err_clr) underflow <= 1'b0;
    end
  end
`else
  logic err_clr_unused;

  assign err_clr_unused = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: directed boundary cases then randomized traffic,
// checked against a queue-based reference model; a monitor compares popped data.
module tb_sync_fifo;

  localparam int W      = 8;
  localparam int DEPTH  = 4;
  localparam int AF_LVL = 3;
  localparam int AE_LVL = 1;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clr = 1'b0;
  logic          we = 1'b0;
  logic [W-1:0]  din = '0;
  logic          re = 1'b0;
  logic          err_clr = 1'b0;
  logic [W-1:0]  dout;
  logic          full, empty, almost_full, almost_empty;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  int tests = 0;
  int fails = 0;

  // Reference model: accepted data in order, plus occupancy and sticky flags.
  logic [W-1:0] exp_q[$];
  int           m_count = 0;
  bit           m_ovf = 0;
  bit           m_udf = 0;

  sync_fifo #(.W(W), .DEPTH(DEPTH), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .din(din), .re(re),
    .err_clr(err_clr), .dout(dout), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: inputs are stable mid-cycle, so a pop that will happen at the next edge
  // is visible now; compare the show-ahead word against the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && !clr && re && !empty) begin
      if (exp_q.size() == 0) begin
        check("pop_with_empty_model", 1, 0);
      end else begin
        check("pop_data", int'(dout), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic check_status(input string tag);
    bit exp_ovf, exp_udf;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    exp_ovf = m_ovf;
    exp_udf = m_udf;
`else
    exp_ovf = 0;
    exp_udf = 0;
`endif
    check({tag, ":count"},        int'(count),        m_count);
    check({tag, ":empty"},        int'(empty),        int'(m_count == 0));
    check({tag, ":full"},         int'(full),         int'(m_count == DEPTH));
    check({tag, ":almost_full"},  int'(almost_full),  int'(m_count >= AF_LVL));
    check({tag, ":almost_empty"}, int'(almost_empty), int'(m_count <= AE_LVL));
    check({tag, ":overflow"},     int'(overflow),     int'(exp_ovf));
    check({tag, ":underflow"},    int'(underflow),    int'(exp_udf));
    if (m_count == 0) check({tag, ":dout_empty"}, int'(dout), 0);
    else if (exp_q.size() > 0) check({tag, ":dout_head"}, int'(dout), int'(exp_q[0]));
  endtask

  // One clock: apply inputs, record expected effects, advance model at the edge, check.
  task automatic cycle(input string tag, input bit w, input bit r, input logic [W-1:0] d,
                       input bit c = 0, input bit rst = 0, input bit ec = 0);
    bit wr_ok, rd_ok, active;
    we = w; re = r; din = d; clr = c; rst_n = ~rst; err_clr = ec;
    active = !rst && !c;
    wr_ok  = w && (m_count < DEPTH || r);
    rd_ok  = r && m_count > 0;
    if (active && wr_ok) exp_q.push_back(d);
    @(posedge clk);
    if (!active) begin
      m_count = 0; m_ovf = 0; m_udf = 0;
      exp_q.delete();
    end else begin
      if (w && m_count == DEPTH && !r) m_ovf = 1;
      else if (ec) m_ovf = 0;
      if (r && m_count == 0) m_udf = 1;
      else if (ec) m_udf = 0;
      m_count = m_count + int'(wr_ok) - int'(rd_ok);
    end
    #1;
    check_status(tag);
  endtask

  initial begin
    cycle("reset", 0, 0, 8'h00, 0, 1);
    // Fill: almost_empty falls after 2nd, almost_full rises after 3rd, full after 4th.
    cycle("fill1", 1, 0, 8'h11);
    cycle("fill2", 1, 0, 8'h22);
    cycle("fill3", 1, 0, 8'h33);
    cycle("fill4", 1, 0, 8'h44);
    check("fill_head", int'(dout), 8'h11);
    // Overflow: rejected write, err_clr, then err_clr colliding with a new overflow.
    cycle("ovf", 1, 0, 8'h55);
    cycle("ovf_clr", 0, 0, 8'h00, 0, 0, 1);
    cycle("ovf_vs_clr", 1, 0, 8'h56, 0, 0, 1);
    // Simultaneous access at full: 0x11 popped, 0x66 queued last.
    cycle("full_rw", 1, 1, 8'h66);
    for (int i = 0; i < 4; i++) cycle("drain", 0, 1, 8'h00);
    // Read on empty, then simultaneous access at empty.
    cycle("udf", 0, 1, 8'h00);
    cycle("empty_rw", 1, 1, 8'h77);
    check("empty_rw_dout", int'(dout), 8'h77);
    cycle("err_clr2", 0, 0, 8'h00, 0, 0, 1);
    // Stream at count 2 across pointer wrap.
    cycle("pre_stream", 1, 0, 8'h80);
    for (int i = 0; i < 10; i++) cycle("stream", 1, 1, 8'(8'h90 + i));
    // Flush with a write in flight, then reset with a write in flight.
    cycle("ovf_again", 1, 0, 8'hA0);
    cycle("ovf_again2", 1, 0, 8'hA1);
    cycle("ovf_again3", 1, 0, 8'hA2);
    cycle("clr_flush", 1, 1, 8'hEE, 1);
    cycle("after_clr", 0, 0, 8'h00);
    cycle("refill1", 1, 0, 8'hB0);
    cycle("refill2", 1, 0, 8'hB1);
    cycle("udf_refill", 0, 0, 8'h00);
    cycle("rst_flush", 1, 0, 8'hEF, 0, 1);
    cycle("after_rst", 0, 0, 8'h00);
    cycle("post_rst_w", 1, 0, 8'hC0);
    cycle("post_rst_r", 0, 1, 8'h00);
    // Randomized traffic with occasional flushes, resets and error clears.
    for (int i = 0; i < 3000; i++) begin
      bit w, r, c, rs, ec;
      w  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 50);
      c  = ($urandom_range(0, 63) == 0);
      rs = ($urandom_range(0, 127) == 0);
      ec = ($urandom_range(0, 7) == 0);
      cycle("rand", w, r, 8'($urandom), c, rs, ec);
    end
    cycle("final_drain", 0, 0, 8'h00);
    check("model_queue_vs_count", exp_q.size(), int'(count));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised synchronous FIFO for the USB datapath, superseding the fixed single-bit, 32-deep FIFO. It generalises the element width and depth and adds show-ahead read data, programmable almost-full/almost-empty thresholds, a synchronous flush, and optional sticky overflow/underflow error flags. It sits between the bit-stuffing and serialisation stages and the packet assembly logic, and is sized per instance.

## Interface
- `W`, default 8: element width in bits, ≥1.
- `DEPTH`, default 32: number of entries; power of two, ≥2.
- `AF_LVL`, default `DEPTH-4`: `almost_full` asserts when `count >= AF_LVL`; legal range 1..`DEPTH`.
- `AE_LVL`, default 4: `almost_empty` asserts when `count <= AE_LVL`; legal range 0..`DEPTH-1`.
- Derived widths: `AW = $clog2(DEPTH)` (pointers), `CW = AW+1` (count).
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `clr` input 1: synchronous flush.
- `we` input 1: write request.
- `din` input W: write data.
- `re` input 1: read request; pops the entry currently shown on `dout`.
- `err_clr` input 1: clears the sticky error flags.
- `dout` output W: head-of-queue data (show-ahead); 0 when empty.
- `full` output 1: `count == DEPTH`.
- `empty` output 1: `count == 0`.
- `almost_full` output 1: `count >= AF_LVL`.
- `almost_empty` output 1: `count <= AE_LVL`.
- `count` output CW: number of stored entries, 0..`DEPTH`.
- `overflow` output 1: sticky flag, set by a write rejected because the FIFO is full.
- `underflow` output 1: sticky flag, set by a read rejected because the FIFO is empty.

## Operation
- **Storage and pointers.** Storage is `DEPTH` x `W` registers. Write pointer `wp` and read pointer `rp` are each `AW` bits wide and wrap modulo `DEPTH` with no special case. `count` is a separate register, not derived from the pointers.
- **Accept rules.**
  - `wr_ok = we & (~full | re)`
  - `rd_ok = re & ~empty`
- **Write.** When `wr_ok`, `mem[wp] <= din` and `wp <= wp+1`.
- **Read.** When `rd_ok`, `rp <= rp+1`.
- **Count update.**
  - `+1` if `wr_ok & ~rd_ok`
  - `-1` if `rd_ok & ~wr_ok`
  - otherwise unchanged
- **Full, with `we` and `re` together.** Both are accepted; `count` stays `DEPTH`. This is not an overflow.
- **Empty, with `we` and `re` together.** The write is accepted and the read is rejected; `count` becomes 1. This is an underflow.
- **Error flags.**
  - `overflow` sets on `we & full & ~re`.
  - `underflow` sets on `re & empty`.
  - `err_clr` clears both. If a set event and `err_clr` occur in the same cycle, the set wins.
- **Priority, highest first:** `~rst_n`, then `clr`, then normal operation.
  - `clr` zeroes `wp`, `rp` and `count`, and clears `overflow` and `underflow`.
  - `clr` ignores `we` and `re` in the same cycle.
  - Memory contents are not cleared by `clr`.
- **Output decoding.** `dout = empty ? 0 : mem[rp]`. All flags decode combinationally from registered `count`, so there is no glitch path from `we`/`re` to the flags.

## Timing
- **Reset values** (after the first rising edge with `rst_n` low):
  - `count` = 0, `empty` = 1, `full` = 0, `dout` = 0.
  - `almost_empty` = 1; `almost_full` = 0 (since `AF_LVL ≥ 1`).
  - `overflow` = 0, `underflow` = 0.
  - Memory is not reset.
- **Reset mid-operation.** Reset during traffic behaves like `clr`: all pending data is discarded on that edge.
- **Write to read.** Data written at edge N appears on `dout`, and `empty` deasserts, after edge N. It can be popped with `re` in cycle N+1. Write-to-read latency is 1 cycle.
- **Read.** `re` at edge N advances `dout` to the next entry after edge N. Read latency is 0: data is valid in the same cycle `re` is sampled.
- **Wrap-around.** After exactly `DEPTH` accepted writes, `wp` returns to 0.
- **Throughput.** Continuous `we & re` sustains one element per cycle at any fill level from 1 to `DEPTH`.

## Configuration
- Macro `SYNC_FIFO_ERR_FLAGS_EN`.
- **Defined:** `overflow`, `underflow` and `err_clr` behave as specified above.
- **Undefined:**
  - `overflow` and `underflow` are tied to 0 and the flag registers are not built.
  - `err_clr` is ignored.
  - The port list is unchanged.
  - Accept rules and all data behaviour are identical in both configurations.

## Test plan
- **Reset then fill.** `W=8`, `DEPTH=4`, `AF_LVL=3`, `AE_LVL=1`. Reset, then write 0x11, 0x22, 0x33, 0x44.
  - `count` steps 1,2,3,4.
  - `almost_empty` falls after the 2nd write.
  - `almost_full` rises after the 3rd write.
  - `full` rises after the 4th write.
  - `dout` = 0x11 throughout.
- **Drain.** Read 4 times: `dout` shows 0x11, 0x22, 0x33, 0x44 in order, then `empty` = 1 and `dout` = 0.
- **Overflow.**
  - While full, write 0x55 with `re` = 0: `count` stays 4, `overflow` = 1, and the data is not stored.
  - `err_clr` clears `overflow`.
  - With `err_clr` and another overflow in the same cycle, `overflow` stays 1.
- **Simultaneous access at the boundaries.**
  - Full with `we=1`, `re=1`, `din=0x66`: `count` stays 4, 0x11 is popped, and 0x66 is read last.
  - Empty with `we=1`, `re=1`, `din=0x77`: `count` = 1, `dout` = 0x77, `underflow` = 1.
- **Wrap and throughput.** Run 10 cycles of streaming `we & re` at `count=2`: data order is preserved across pointer wrap and `count` stays 2.
- **Flush versus reset.**
  - Mid-stream `clr` with `we=1`: `count` = 0, `empty` = 1, flags are cleared, and the write is dropped.
  - Repeat using `rst_n` low for one edge: same result.
  - Build with `SYNC_FIFO_ERR_FLAGS_EN` undefined: the overflow scenario shows `overflow` = 0.
